// File: rtl/pipe_stage_skid_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_skid_pkg
//  Description : Shared pipeline definitions. Holds the stage-register state
//                encoding and the payload widths used between CPU stages.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_stage_skid_pkg;

  // The state value equals the number of held entries, so occupancy is a
  // direct copy of the state register.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_e;

  // Payload widths carried between CPU stages.
  localparam int unsigned ALU_OUT_W  = 32;
  localparam int unsigned RS2_DATA_W = 32;
  localparam int unsigned EX_MEM_W   = ALU_OUT_W + RS2_DATA_W;

  // Number of entries held in a given state.
  function automatic logic [1:0] state_occupancy(input pipe_state_e s);
    return 2'(s);
  endfunction

endpackage : pipe_stage_skid_pkg
`default_nettype wire

// File: rtl/pipe_data_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_data_reg
//  Description : DATA_W-bit storage register with asynchronous active-low
//                reset, load enable and a synchronous clear that wins over
//                the load.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_data_reg #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;

  // Next value: clear has priority, otherwise load, otherwise hold.
  always_comb begin
    data_d = data_q;
    if (clr) begin
      data_d = '0;
    end else if (load) begin
      data_d = d;
    end
  end

  // Storage flop, zeroed while reset is held low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule : pipe_data_reg
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_skid
//  Description : Parametrised valid/ready pipeline stage register with
//                synchronous flush. SKID_EN=1 builds a two-entry skid buffer
//                whose in_ready comes from state flops only; SKID_EN=0 builds
//                a single register with combinational in_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int DATA_W         = EX_MEM_W,
  parameter int SKID_EN        = 1,
  parameter int CLEAR_ON_FLUSH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  pipe_state_e       state_q;
  pipe_state_e       state_d;
  logic              main_valid;
  logic              skid_valid;
  logic              in_xfer;
  logic              out_xfer;
  logic              main_load;
  logic              main_sel_skid;
  logic              data_clr;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;

  assign main_valid = (state_q != ST_EMPTY);
  assign skid_valid = (state_q == ST_SKID);
  assign in_xfer    = in_valid && in_ready;
  assign out_xfer   = main_valid && out_ready;
  assign data_clr   = flush && (CLEAR_ON_FLUSH != 0);

  // Ready generation differs per flavour: the skid variant must not see
  // out_ready combinationally, the plain variant may pass it straight back.
  generate
    if (SKID_EN != 0) begin : g_ready_skid
      assign in_ready = !skid_valid;
    end else begin : g_ready_plain
      assign in_ready = out_ready || !main_valid;
    end
  endgenerate

  // Next-state and main-register load control; flush overrides everything.
  always_comb begin
    state_d       = state_q;
    main_load     = 1'b0;
    main_sel_skid = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d   = ST_FULL;
            main_load = 1'b1;
          end
        end
        ST_FULL: begin
          if (in_xfer && out_xfer) begin
            main_load = 1'b1;
          end else if (in_xfer) begin
            // Only reachable with the skid buffer: plain mode deasserts
            // in_ready whenever it is full and not draining.
            state_d = ST_SKID;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_xfer) begin
            state_d       = ST_FULL;
            main_load     = 1'b1;
            main_sel_skid = 1'b1;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Main register refills from the skid entry when it drains, otherwise
  // straight from the upstream payload.
  assign main_d = main_sel_skid ? skid_q : in_data;

  pipe_data_reg #(
    .DATA_W (DATA_W)
  ) u_main_reg (
    .clk  (clk),
    .rst  (rst),
    .clr  (data_clr),
    .load (main_load),
    .d    (main_d),
    .q    (main_q)
  );

  generate
    if (SKID_EN != 0) begin : g_skid_reg
      logic skid_load;

      // The skid entry captures a payload that arrives while main is
      // stalled downstream.
      assign skid_load = !flush && (state_q == ST_FULL) && in_xfer && !out_xfer;

      pipe_data_reg #(
        .DATA_W (DATA_W)
      ) u_skid_reg (
        .clk  (clk),
        .rst  (rst),
        .clr  (data_clr),
        .load (skid_load),
        .d    (in_data),
        .q    (skid_q)
      );
    end else begin : g_no_skid_reg
      assign skid_q = '0;
    end
  endgenerate

  assign out_valid = main_valid;
  assign out_data  = main_q;
  assign occupancy = state_occupancy(state_q);

endmodule : pipe_stage_skid
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_skid
//  Description : Self-checking bench for pipe_stage_skid. Instance 0 is the
//                plain register (SKID_EN=0), instance 1 the skid buffer
//                (SKID_EN=1). Both are compared every cycle against a small
//                FIFO-of-payloads reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;

  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [1:0]           flush;
  logic [1:0]           in_valid;
  logic [1:0]           out_ready;
  logic [1:0][DW-1:0]   in_data;
  logic [1:0]           in_ready;
  logic [1:0]           out_valid;
  logic [1:0][DW-1:0]   out_data;
  logic [1:0][1:0]      occupancy;

  int n_checks;
  int n_errors;

  // Reference model: an ordered list of held payloads per instance, plus the
  // value out_data must show when nothing is held.
  logic [DW-1:0] m_buf  [2][2];
  int            m_cnt  [2];
  logic [DW-1:0] m_last [2];

  pipe_stage_skid #(
    .DATA_W (DW), .SKID_EN (0), .CLEAR_ON_FLUSH (1)
  ) dut_plain (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush[0]),
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready[0]),
    .in_data   (in_data[0]),
    .out_valid (out_valid[0]),
    .out_ready (out_ready[0]),
    .out_data  (out_data[0]),
    .occupancy (occupancy[0])
  );

  pipe_stage_skid #(
    .DATA_W (DW), .SKID_EN (1), .CLEAR_ON_FLUSH (1)
  ) dut_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush[1]),
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready[1]),
    .in_data   (in_data[1]),
    .out_valid (out_valid[1]),
    .out_ready (out_ready[1]),
    .out_data  (out_data[1]),
    .occupancy (occupancy[1])
  );

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  // Skid instance: room whenever fewer than two are held.
  // Plain instance: room when empty or when the held payload leaves now.
  function automatic bit m_ready(input int d);
    if (d == 1) return (m_cnt[d] < 2);
    return (m_cnt[d] == 0) || (out_ready[d] == 1'b1);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cnt[d]    = 0;
      m_last[d]   = '0;
      m_buf[d][0] = '0;
      m_buf[d][1] = '0;
    end
  endtask

  task automatic drive(input int d, input bit v, input logic [DW-1:0] data, input bit ordy, input bit fl);
    in_valid[d]  = v;
    in_data[d]   = data;
    out_ready[d] = ordy;
    flush[d]     = fl;
  endtask

  // Compare both instances with the model, then advance one clock edge.
  task automatic tick();
    bit            ix [2];
    bit            ox [2];
    bit            fl [2];
    logic [DW-1:0] di [2];
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("in_ready",  d, 32'(in_ready[d]),  32'(m_ready(d)));
      chk("out_valid", d, 32'(out_valid[d]), 32'(m_cnt[d] != 0));
      chk("out_data",  d, 32'(out_data[d]),  32'((m_cnt[d] != 0) ? m_buf[d][0] : m_last[d]));
      chk("occupancy", d, 32'(occupancy[d]), 32'(m_cnt[d]));
      ix[d] = in_valid[d] && m_ready(d);
      ox[d] = (m_cnt[d] != 0) && out_ready[d];
      fl[d] = flush[d];
      di[d] = in_data[d];
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (fl[d]) begin
        m_cnt[d]  = 0;
        m_last[d] = '0;
      end else begin
        if (ox[d]) begin
          m_last[d]   = m_buf[d][0];
          m_buf[d][0] = m_buf[d][1];
          m_cnt[d]    = m_cnt[d] - 1;
        end
        if (ix[d]) begin
          m_buf[d][m_cnt[d]] = di[d];
          m_cnt[d]           = m_cnt[d] + 1;
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b0;
    drive(0, 0, '0, 0, 0);
    drive(1, 0, '0, 0, 0);
    model_reset();

    // Reset values while reset is held.
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_out_valid", d, 32'(out_valid[d]), 32'd0);
      chk("rst_out_data",  d, 32'(out_data[d]),  32'd0);
      chk("rst_occupancy", d, 32'(occupancy[d]), 32'd0);
      chk("rst_in_ready",  d, 32'(in_ready[d]),  32'd1);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Streaming through the skid instance with no backpressure.
    drive(1, 1, 16'h1, 1, 0); tick();
    chk("stream1_data", 1, 32'(out_data[1]), 32'h1);
    chk("stream1_occ",  1, 32'(occupancy[1]), 32'd1);
    drive(1, 1, 16'h2, 1, 0); tick();
    chk("stream2_data", 1, 32'(out_data[1]), 32'h2);
    chk("stream2_vld",  1, 32'(out_valid[1]), 32'd1);
    drive(1, 1, 16'h3, 1, 0); tick();
    chk("stream3_data", 1, 32'(out_data[1]), 32'h3);
    chk("stream3_occ",  1, 32'(occupancy[1]), 32'd1);
    drive(1, 0, '0, 1, 0); tick();
    chk("stream_drain_vld", 1, 32'(out_valid[1]), 32'd0);

    // Backpressure fills both entries, then drains in order.
    drive(1, 1, 16'hA, 0, 0); tick();
    drive(1, 1, 16'hB, 0, 0); tick();
    chk("bp_occ2",      1, 32'(occupancy[1]), 32'd2);
    chk("bp_in_ready0", 1, 32'(in_ready[1]),  32'd0);
    chk("bp_head",      1, 32'(out_data[1]),  32'hA);
    drive(1, 0, '0, 1, 0); tick();
    chk("bp_second",    1, 32'(out_data[1]),  32'hB);
    chk("bp_in_ready1", 1, 32'(in_ready[1]),  32'd1);
    tick();
    chk("bp_empty_vld", 1, 32'(out_valid[1]), 32'd0);
    chk("bp_hold_data", 1, 32'(out_data[1]),  32'hB);

    // Flush at occupancy 2 discards the held entries and the offered 0xC.
    drive(1, 1, 16'hA, 0, 0); tick();
    drive(1, 1, 16'hB, 0, 0); tick();
    drive(1, 1, 16'hC, 0, 1); tick();
    chk("flush_occ",  1, 32'(occupancy[1]), 32'd0);
    chk("flush_vld",  1, 32'(out_valid[1]), 32'd0);
    chk("flush_data", 1, 32'(out_data[1]),  32'd0);
    drive(1, 0, '0, 1, 0); tick(); tick();
    chk("flush_no_c", 1, 32'(out_valid[1]), 32'd0);

    // Flush at occupancy 1 with in_ready high still discards the input.
    drive(1, 1, 16'hD, 0, 0); tick();
    drive(1, 1, 16'hE, 0, 1); tick();
    chk("flush1_vld", 1, 32'(out_valid[1]), 32'd0);
    drive(1, 0, '0, 1, 0); tick();
    chk("flush1_no_e", 1, 32'(out_valid[1]), 32'd0);

    // Plain instance stall and simultaneous unload/load.
    drive(0, 1, 16'h5, 0, 0); tick();
    chk("plain_hold5", 0, 32'(out_data[0]), 32'h5);
    drive(0, 1, 16'h6, 0, 0);
    #1;
    chk("plain_stall_rdy", 0, 32'(in_ready[0]), 32'd0);
    out_ready[0] = 1'b1;
    #1;
    chk("plain_comb_rdy", 0, 32'(in_ready[0]), 32'd1);
    tick();
    chk("plain_load6", 0, 32'(out_data[0]),  32'h6);
    chk("plain_occ",   0, 32'(occupancy[0]), 32'd1);
    drive(0, 0, '0, 1, 0); tick();
    chk("plain_empty", 0, 32'(out_valid[0]), 32'd0);
    chk("plain_held",  0, 32'(out_data[0]),  32'h6);

    // Asynchronous reset mid-stream: skid instance at occupancy 2.
    drive(1, 1, 16'h11, 0, 0); drive(0, 1, 16'h21, 0, 0); tick();
    drive(1, 1, 16'h12, 0, 0); drive(0, 0, '0, 0, 0);     tick();
    chk("pre_rst_occ", 1, 32'(occupancy[1]), 32'd2);
    drive(1, 0, '0, 0, 0);
    rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("arst_out_valid", d, 32'(out_valid[d]), 32'd0);
      chk("arst_out_data",  d, 32'(out_data[d]),  32'd0);
      chk("arst_occupancy", d, 32'(occupancy[d]), 32'd0);
      chk("arst_in_ready",  d, 32'(in_ready[d]),  32'd1);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Random concurrency on both instances.
    for (int i = 0; i < 3000; i++) begin
      for (int d = 0; d < 2; d++) begin
        drive(d, ($urandom % 4) != 0, DW'($urandom), ($urandom % 3) != 0, ($urandom % 40) == 0);
      end
      tick();
    end

    // Drain and confirm nothing is left behind.
    drive(0, 0, '0, 1, 0);
    drive(1, 0, '0, 1, 0);
    for (int i = 0; i < 4; i++) tick();
    for (int d = 0; d < 2; d++) begin
      chk("final_occ", d, 32'(occupancy[d]), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_pipe_stage_skid
`default_nettype wire

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised pipeline stage register, the generalised successor of the fixed-width stage registers between pipeline stages. Carries a DATA_W-bit payload with a valid/ready handshake, stall backpressure and synchronous flush. SKID_EN selects a plain stalled register or a two-entry skid buffer that registers the upstream ready path. Sits between any two CPU pipeline stages, for example EX->MEM carrying {alu_out, rs2_data}.

Parameters:
DATA_W, 64, payload width in bits; must be >= 1.
SKID_EN, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
CLEAR_ON_FLUSH, 1, 1 = flush also zeroes the stored data; 0 = flush clears only the valid flags.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-low reset.
flush  input  1  synchronous kill of all held entries and of any input accepted in the same cycle.
in_valid  input  1  upstream has a payload.
in_ready  output  1  stage can accept a payload this cycle.
in_data  input  DATA_W  upstream payload.
out_valid  output  1  out_data is a valid payload.
out_ready  input  1  downstream accepts out_data this cycle.
out_data  output  DATA_W  payload presented downstream, driven straight from the main register.
occupancy  output  2  number of held entries: 0, 1 or 2 (2 only when SKID_EN=1).

Behaviour:
- Transfer rules: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready. Both may occur in the same cycle.
- Reset (rst=0, asynchronous): main_valid=0, skid_valid=0, main and skid data=0, out_valid=0, out_data=0, occupancy=0. in_ready=1 while reset is held and after it is released.
- Latency: 1 cycle. A payload accepted at edge N is on out_data with out_valid=1 after edge N.
- SKID_EN=0:
  - in_ready = out_ready || !main_valid.
  - On an input transfer: main <= in_data, main_valid <= 1.
  - On an output transfer with no input transfer: main_valid <= 0; data is held.
- SKID_EN=1, states EMPTY (occ 0), FULL (occ 1), SKID (occ 2):
  - in_ready = !skid_valid, taken from a register with no combinational path from out_ready.
  - EMPTY + input -> FULL; main <= in_data.
  - FULL + input only -> SKID; skid <= in_data.
  - FULL + output only -> EMPTY.
  - FULL + input and output -> FULL; main <= in_data.
  - SKID + output -> FULL; main <= skid.
  - SKID: no input is possible because in_ready=0.
  - All other combinations hold state.
- Ordering is strict FIFO. A payload is never duplicated and never dropped except by flush.
- flush=1 overrides everything else at that edge:
  - Next state is EMPTY and occupancy becomes 0.
  - An in_valid presented while flush=1 is discarded, although in_ready may read 1.
  - An output transfer in the flush cycle still counts as delivered downstream.
  - With CLEAR_ON_FLUSH=1, main and skid data become 0.
- Reset mid-operation: immediate return to reset values regardless of state, with no handshake completion implied.
- Data is never modified; the stage is width-agnostic pass-through. When out_valid=0, out_data holds the last value, or 0 after reset or a clearing flush.

Decomposition:
- Shared pipeline package holds the state encoding (EMPTY=2'd0, FULL=2'd1, SKID=2'd2) and the payload width constants used by the CPU stages, for example an EX/MEM payload width of 64.
- Natural sub-module: pipe_data_reg, a DATA_W register with async active-low reset, load enable and sync clear. It is instantiated once for main, and once more for skid under SKID_EN.

Test Plan:
- Reset: drive rst=0 mid-stream with occupancy=2 -> out_valid=0, out_data=0, occupancy=0, in_ready=1 immediately, without waiting for a clock edge.
- Streaming, SKID_EN=1, out_ready=1: send 0x1, 0x2, 0x3 on consecutive cycles -> out_data shows 0x1, 0x2, 0x3 one cycle later each, out_valid stays 1, occupancy stays 1, no bubbles.
- Backpressure: hold out_ready=0 and send 0xA then 0xB -> occupancy reaches 2 and in_ready=0. Raise out_ready -> 0xA then 0xB leave on consecutive cycles, and in_ready returns to 1 one cycle after 0xA leaves.
- Flush: at occupancy=2, assert flush with in_valid=1 and in_data=0xC -> next cycle occupancy=0, out_valid=0, out_data=0 (CLEAR_ON_FLUSH=1), and 0xC never appears.
- SKID_EN=0 stall: out_ready=0 with main holding 0x5 -> in_ready=0 combinationally. Raise out_ready with in_data=0x6 -> 0x5 transfers out and 0x6 loads on the same edge.
- Random concurrency, SKID_EN in {0,1}: random in_valid, out_ready and occasional flush checked against a reference queue model -> no loss, duplication or reordering of non-flushed payloads.
